tick_divider_bank: RTL
======================

# tick_divider_bank

Multi-channel programmable tick generator, the parametrised successor of the fixed single-output clock divider. It derives CHANNELS independent or cascaded tick streams from `clk_in`, such as 1 Hz seconds, minutes, the display-multiplex rate and the alarm beeper rate. Each channel has a runtime divisor, an enable, an optional cascade from the previous channel and a toggling square output. It sits between the board oscillator and the timekeeping, display and alarm logic. All outputs are synchronous to `clk_in`.

## Interface
Parameters:
- `CHANNELS`, default 4: number of divider channels, ≥1.
- `CNT_W`, default 16: divisor/counter width in bits.
- `DEFAULT_DIV`, default 16: divisor loaded into every channel at reset; must satisfy 1 ≤ DEFAULT_DIV < 2^CNT_W.

Ports:
- `clk_in` in 1: sole clock.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in CHANNELS: per-channel advance enable.
- `sync_restart` in 1: one-cycle pulse that realigns all channels.
- `cfg_we` in 1: configuration write strobe.
- `cfg_ch` in max(1,$clog2(CHANNELS)): channel addressed by the write.
- `cfg_div` in CNT_W: new divisor D.
- `cfg_cascade` in 1: the channel advances on the previous channel's wrap instead of every cycle.
- `tick` out CHANNELS: one-cycle pulse per wrap, registered.
- `sq_out` out CHANNELS: square wave that toggles on every wrap, registered.

## Operation
- Per-channel state: `div` (CNT_W), `cnt` (CNT_W), `cascade` (1), `tick` (1) and `sq_out` (1).
- Reset values: div = DEFAULT_DIV, cnt = DEFAULT_DIV−1, cascade = 0, tick = 0, sq_out = 0, for all channels.
- Effective divisor: Deff = max(div,1), so D = 0 behaves as D = 1.
- Advance condition `adv[i]` = enable[i] && (cascade[i] ? wrap[i−1] : 1).
  - Channel 0 ignores its cascade bit and always uses the non-cascaded form.
  - A cascade bit written to channel 0 is stored but has no effect.
- Wrap condition `wrap[i]` = adv[i] && cnt[i] == 0. It is combinational, and the cascade chain ripples within one cycle.
- Counter update on adv[i]:
  - cnt ← (cnt == 0) ? Deff−1 : cnt−1.
  - With enable low the counter holds and no wrap occurs.
- Outputs: tick[i] ← wrap[i]; sq_out[i] ← sq_out[i] ^ wrap[i].
- Tick period is Deff advances. The sq_out period is 2·Deff advances with 50 % duty.
- Config write (cfg_we high, cfg_ch < CHANNELS):
  - div[cfg_ch] ← cfg_div; cascade[cfg_ch] ← cfg_cascade.
  - cnt[cfg_ch] ← max(cfg_div,1)−1.
  - tick[cfg_ch] ← 0 in that cycle, even if a wrap was due. sq_out holds.
  - Other channels are unaffected.
  - A write with cfg_ch ≥ CHANNELS is ignored.
- sync_restart:
  - Every cnt reloads to Deff−1 and every sq_out clears to 0.
  - Every tick is forced to 0 that cycle.
  - div and cascade are unchanged.
- sync_restart together with cfg_we: the write's div and cascade are stored, and the addressed channel reloads from the new divisor. sync_restart still clears all sq_out and suppresses all ticks.
- A channel in cascade mode whose predecessor is disabled never advances.

## Timing
- The tick rises one cycle after the cycle in which cnt == 0 and adv hold.
- With a non-cascaded channel enabled and D = N, the first tick after reset or reload appears N cycles later. Ticks then repeat every N cycles.
- Cascaded channels see zero added latency per stage: tick[i] and tick[i−1] assert in the same cycle when both wrap.
- D = 1, non-cascaded: tick stays continuously high and sq_out toggles every cycle.
- Reset is asynchronous on assertion and acts mid-count. The first advance happens on the first clock edge after deassertion.
- The critical path is the CHANNELS-deep cascade ripple. This is acceptable for CHANNELS ≤ 8 at the board clock.

## Structure
- Package `tick_div_pkg`:
  - `tick_chan_cfg_t` struct holding div and cascade.
  - Function `eff_div(d)` returning max(d,1).
  - Constant for the default channel count.
- Sub-module `tick_div_channel`: one counter with its div, cascade, tick and sq_out registers.
  - Inputs: adv_src, enable, load, restart, cfg.
  - Outputs: wrap (comb), tick, sq_out.
- The top level generates CHANNELS instances, chains wrap[i−1] into adv_src[i], and decodes cfg_ch.

## Test plan
- Reset with DEFAULT_DIV = 16, all enabled:
  - Tick pulses first at cycle 16 after deassertion, then every 16 cycles.
  - sq_out toggles at each tick, giving a 32-cycle period.
- Write ch1 D = 5 mid-count:
  - tick[1] is suppressed in the write cycle.
  - Next tick[1] comes 5 cycles later, then every 5.
  - Channels 0, 2 and 3 keep their phase.
- ch0 D = 4, ch1 D = 3 cascade, ch2 D = 2 cascade:
  - tick[1] every 12 cycles, coincident with tick[0].
  - tick[2] every 24 cycles, coincident with both.
- Write D = 0 and D = 1 on ch3:
  - Both give tick[3] high every cycle and sq_out[3] toggling every cycle.
- Drop enable[0] for 7 cycles with D = 10:
  - The tick is delayed by exactly 7 cycles.
  - The cascaded ch1 stalls during the gap.
- sync_restart with a simultaneous cfg write to ch2 (D = 6), then reset asserted mid-count:
  - After the restart all sq_out = 0 and no ticks occur that cycle.
  - ch2 ticks 6 cycles later.
  - The reset returns every channel to the DEFAULT_DIV values.

Source files
------------

// File: rtl/tick_div_pkg.sv
// tick_div_pkg: shared types and helpers for the tick divider bank
package tick_div_pkg;
  localparam int DEF_CHANNELS = 4;
  localparam int MAX_CNT_W = 32;
  typedef struct packed {
    logic [MAX_CNT_W-1:0] div;
    logic                 cascade;
  } tick_chan_cfg_t;
  // A divisor of zero behaves as one so the counter always has a valid period
  function automatic logic [MAX_CNT_W-1:0] eff_div(input logic [MAX_CNT_W-1:0] d);
    return (d == '0) ? MAX_CNT_W'(1) : d;
  endfunction
endpackage

// File: rtl/tick_div_channel.sv
// tick_div_channel: one programmable down-counter with registered tick and square outputs
module tick_div_channel import tick_div_pkg::*; #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 16
) (
  input  logic           clk_in,
  input  logic           reset,
  input  logic           adv_src,
  input  logic           enable,
  input  logic           load,
  input  logic           restart,
  input  tick_chan_cfg_t cfg,
  output logic           wrap,
  output logic           tick,
  output logic           sq_out
);
  logic [CNT_W-1:0] div_q, div_d, cnt_q, cnt_d, rel_cur, rel_new;
  logic cascade_q, cascade_d, tick_q, tick_d, sq_q, sq_d, adv;
  assign rel_cur = CNT_W'(eff_div(MAX_CNT_W'(div_q))) - CNT_W'(1);
  assign rel_new = CNT_W'(eff_div(cfg.div)) - CNT_W'(1);
  // The head channel is fed adv_src = 1, so its cascade bit has no effect
  always_comb begin
    adv       = enable & (adv_src | ~cascade_q);
    wrap      = adv & (cnt_q == '0);
    div_d     = load ? CNT_W'(cfg.div) : div_q;
    cascade_d = load ? cfg.cascade : cascade_q;
    cnt_d     = load ? rel_new : restart ? rel_cur : !adv ? cnt_q : wrap ? rel_cur : cnt_q - CNT_W'(1);
    tick_d    = wrap & ~load & ~restart;
    sq_d      = restart ? 1'b0 : load ? sq_q : sq_q ^ wrap;
  end
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      div_q     <= CNT_W'(DEFAULT_DIV);
      cnt_q     <= CNT_W'(DEFAULT_DIV - 1);
      cascade_q <= 1'b0;
      tick_q    <= 1'b0;
      sq_q      <= 1'b0;
    end else begin
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      cascade_q <= cascade_d;
      tick_q    <= tick_d;
      sq_q      <= sq_d;
    end
  end
  assign tick   = tick_q;
  assign sq_out = sq_q;
endmodule

// File: rtl/tick_divider_bank.sv
// tick_divider_bank: bank of programmable, optionally cascaded tick generators
module tick_divider_bank import tick_div_pkg::*; #(
  parameter int CHANNELS    = DEF_CHANNELS,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 16,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic [CHANNELS-1:0] enable,
  input  logic                sync_restart,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]    cfg_div,
  input  logic                cfg_cascade,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] sq_out
);
  tick_chan_cfg_t cfg;
  logic [CHANNELS-1:0] wrap, adv_src;
  logic unused_wrap;
  assign cfg = '{div: MAX_CNT_W'(cfg_div), cascade: cfg_cascade};
  genvar i;
  // Wraps ripple combinationally down the chain, so cascaded stages add no latency
  for (i = 0; i < CHANNELS; i++) begin : g_ch
    if (i == 0) begin : g_head
      assign adv_src[i] = 1'b1;
    end else begin : g_link
      assign adv_src[i] = wrap[i-1];
    end
    tick_div_channel #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
      .clk_in  (clk_in),
      .reset   (reset),
      .adv_src (adv_src[i]),
      .enable  (enable[i]),
      .load    (cfg_we && cfg_ch == CH_W'(i)),
      .restart (sync_restart),
      .cfg     (cfg),
      .wrap    (wrap[i]),
      .tick    (tick[i]),
      .sq_out  (sq_out[i])
    );
  end
  assign unused_wrap = wrap[CHANNELS-1];
endmodule
